// File: rtl/bits_debounce.sv
// Per-bit debounce with registered level and one-cycle rise/fall pulses.
// Optional sticky edge flags when BITS_DEBOUNCE_STICKY_EN is defined.
module bits_debounce #(
   parameter int unsigned          BUS_WIDTH       = 1,
   parameter int unsigned          DEBOUNCE_CYCLES = 16,
   parameter logic [BUS_WIDTH-1:0] RESET_VAL       = '0
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic [BUS_WIDTH-1:0] i_data,
   output logic [BUS_WIDTH-1:0] o_level,
   output logic [BUS_WIDTH-1:0] o_rise,
   output logic [BUS_WIDTH-1:0] o_fall
`ifdef BITS_DEBOUNCE_STICKY_EN
   ,
   input  logic [BUS_WIDTH-1:0] i_evt_clr,
   output logic [BUS_WIDTH-1:0] o_evt_sticky
`endif
);

   localparam int unsigned    CW     = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] THRESH = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0]        r_cnt     [BUS_WIDTH];
   logic [CW-1:0]        w_cnt_nxt [BUS_WIDTH];
   logic [BUS_WIDTH-1:0] w_lvl_nxt;
   logic [BUS_WIDTH-1:0] w_rise;
   logic [BUS_WIDTH-1:0] w_fall;

   // A differing sample advances the count; a matching sample restarts it.
   always_comb begin
      w_lvl_nxt = o_level;
      w_rise    = '0;
      w_fall    = '0;
      for (int i = 0; i < BUS_WIDTH; i++) begin
         w_cnt_nxt[i] = '0;
         if (i_data[i] != o_level[i]) begin
            if (r_cnt[i] == THRESH) begin
               w_lvl_nxt[i] = i_data[i];
               w_rise[i]    = i_data[i];
               w_fall[i]    = ~i_data[i];
            end else begin
               w_cnt_nxt[i] = r_cnt[i] + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt   <= '{default: '0};
         o_level <= RESET_VAL;
         o_rise  <= '0;
         o_fall  <= '0;
      end else begin
         r_cnt   <= w_cnt_nxt;
         o_level <= w_lvl_nxt;
         o_rise  <= w_rise;
         o_fall  <= w_fall;
      end
   end

`ifdef BITS_DEBOUNCE_STICKY_EN
   // Set on the pulse edge; set has priority over clear.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_evt_sticky <= '0;
      end else begin
         o_evt_sticky <= (o_evt_sticky & ~i_evt_clr) | w_rise | w_fall;
      end
   end
`else
   // No sticky flag state in this build.
`endif

endmodule

// File: tb/tb_bits_debounce.sv
// Randomized + directed bench for bits_debounce against a sample-history model.
// Two instances: N=16 with RESET_VAL=4'b0101, and N=1.
module tb_bits_debounce;

   localparam logic [3:0] RV0 = 4'b0101;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] d0, d1;
   logic [3:0] lvl0, rise0, fall0, lvl1, rise1, fall1;
`ifdef BITS_DEBOUNCE_STICKY_EN
   logic [3:0] clr0, clr1, stk0, stk1;
`endif

   always #5 clk = ~clk;

   bits_debounce #(.BUS_WIDTH(4), .DEBOUNCE_CYCLES(16), .RESET_VAL(RV0)) u_dut0 (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_data  (d0),
      .o_level (lvl0),
      .o_rise  (rise0),
      .o_fall  (fall0)
`ifdef BITS_DEBOUNCE_STICKY_EN
      ,
      .i_evt_clr    (clr0),
      .o_evt_sticky (stk0)
`endif
   );

   bits_debounce #(.BUS_WIDTH(4), .DEBOUNCE_CYCLES(1), .RESET_VAL(4'b0000)) u_dut1 (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_data  (d1),
      .o_level (lvl1),
      .o_rise  (rise1),
      .o_fall  (fall1)
`ifdef BITS_DEBOUNCE_STICKY_EN
      ,
      .i_evt_clr    (clr1),
      .o_evt_sticky (stk1)
`endif
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   // Model: per bit, the samples seen since the last accepted level (last N kept).
   int unsigned nthr [2] = '{16, 1};
   logic [3:0]  rv   [2] = '{RV0, 4'b0000};
   bit          hist [2][4][$];
   logic [3:0]  m_lvl  [2];
   logic [3:0]  m_rise [2];
   logic [3:0]  m_fall [2];
   logic [3:0]  m_stk;

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int b = 0; b < 4; b++) hist[d][b].delete();
         m_lvl[d]  = rv[d];
         m_rise[d] = '0;
         m_fall[d] = '0;
      end
      m_stk = '0;
   endtask

   task automatic model_edge();
      logic [3:0] din [2];
      bit         all_diff;
      din[0] = d0;
      din[1] = d1;
      for (int d = 0; d < 2; d++) begin
         m_rise[d] = '0;
         m_fall[d] = '0;
         for (int b = 0; b < 4; b++) begin
            hist[d][b].push_back(din[d][b]);
            if (hist[d][b].size() > nthr[d]) void'(hist[d][b].pop_front());
            if (hist[d][b].size() == nthr[d]) begin
               all_diff = 1'b1;
               for (int k = 0; k < hist[d][b].size(); k++)
                  if (hist[d][b][k] == m_lvl[d][b]) all_diff = 1'b0;
               if (all_diff) begin
                  m_lvl[d][b] = din[d][b];
                  if (din[d][b]) m_rise[d][b] = 1'b1;
                  else           m_fall[d][b] = 1'b1;
                  hist[d][b].delete();
               end
            end
         end
      end
`ifdef BITS_DEBOUNCE_STICKY_EN
      m_stk = (m_stk & ~clr0) | m_rise[0] | m_fall[0];
`endif
   endtask

   task automatic compare_all(input string ph);
      check({ph, " lvl0"},  32'(lvl0),  32'(m_lvl[0]));
      check({ph, " rise0"}, 32'(rise0), 32'(m_rise[0]));
      check({ph, " fall0"}, 32'(fall0), 32'(m_fall[0]));
      check({ph, " lvl1"},  32'(lvl1),  32'(m_lvl[1]));
      check({ph, " rise1"}, 32'(rise1), 32'(m_rise[1]));
      check({ph, " fall1"}, 32'(fall1), 32'(m_fall[1]));
      check({ph, " excl0"}, 32'(rise0 & fall0), 32'd0);
`ifdef BITS_DEBOUNCE_STICKY_EN
      check({ph, " stk0"},  32'(stk0),  32'(m_stk));
`endif
   endtask

   task automatic step(input string ph);
      @(posedge clk);
      model_edge();
      #1;
      compare_all(ph);
   endtask

   logic [3:0] prev1;

   initial begin
      rst = 1'b1;
      d0  = RV0;
      d1  = 4'b0000;
`ifdef BITS_DEBOUNCE_STICKY_EN
      clr0 = '0;
      clr1 = '0;
`endif
      model_reset();

      // Reset state and clean release
      #22;
      check("rst lvl0", 32'(lvl0), 32'(RV0));
      check("rst rise0", 32'(rise0), 32'd0);
      check("rst fall0", 32'(fall0), 32'd0);
      check("rst lvl1", 32'(lvl1), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step("rel");
         check("rel nopulse", 32'(rise0 | fall0), 32'd0);
      end

      // Bit1 rises after exactly 16 edges
      d0 = 4'b0111;
      for (int i = 1; i <= 16; i++) begin
         step("t2");
         if (i == 15) check("t2 lvl@15", 32'(lvl0), 32'(RV0));
         if (i == 16) begin
            check("t2 lvl@16", 32'(lvl0), 32'(4'b0111));
            check("t2 rise@16", 32'(rise0), 32'(4'b0010));
         end
      end
      step("t2");
      check("t2 rise 1cyc", 32'(rise0), 32'd0);

      // Bit1 falls and bit3 rises on the same edge
      d0 = 4'b1101;
      for (int i = 1; i <= 16; i++) step("t4");
      check("t4 fall", 32'(fall0), 32'(4'b0010));
      check("t4 rise", 32'(rise0), 32'(4'b1000));
      check("t4 lvl", 32'(lvl0), 32'(4'b1101));

      // Glitch at sample 16 restarts the count
      d0 = 4'b1111;
      for (int i = 0; i < 15; i++) step("t3");
      d0 = 4'b1101;
      step("t3");
      d0 = 4'b1111;
      for (int i = 1; i <= 16; i++) begin
         step("t3");
         if (i == 15) check("t3 lvl@15", 32'(lvl0), 32'(4'b1101));
      end
      check("t3 lvl@16", 32'(lvl0), 32'(4'b1111));
      check("t3 rise@16", 32'(rise0), 32'(4'b0010));

      // N=1 follows input with one cycle delay
      prev1 = lvl1;
      for (int i = 0; i < 8; i++) begin
         d1 = (i % 2 == 0) ? 4'b0101 : 4'b1010;
         step("t5");
         check("t5 lvl", 32'(lvl1), 32'(d1));
         check("t5 rise", 32'(rise1), 32'(d1 & ~prev1));
         check("t5 fall", 32'(fall1), 32'(~d1 & prev1));
         prev1 = d1;
      end

      // Reset mid-count discards progress immediately
      d0 = 4'b0000;
      for (int i = 0; i < 8; i++) step("mid");
      #2 rst = 1'b1;
      #1;
      check("mid rst lvl0", 32'(lvl0), 32'(RV0));
      check("mid rst lvl1", 32'(lvl1), 32'd0);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 16; i++) step("post");
      check("post lvl0", 32'(lvl0), 32'd0);

`ifdef BITS_DEBOUNCE_STICKY_EN
      // Sticky set, clear, and set-beats-clear
      clr0 = 4'hF;
      step("s");
      clr0 = 4'h0;
      d0   = 4'b0001;
      for (int i = 0; i < 16; i++) step("s");
      check("s set", 32'(stk0), 32'(4'b0001));
      clr0 = 4'b0001;
      step("s");
      check("s clr", 32'(stk0), 32'd0);
      clr0 = 4'b0000;
      d0   = 4'b0000;
      for (int i = 0; i < 15; i++) step("s");
      clr0 = 4'b0001;
      step("s");
      check("s set>clr", 32'(stk0), 32'(4'b0001));
      clr0 = 4'b0000;
`endif

      // Random: slow-toggling bits on N=16, full random on N=1
      for (int i = 0; i < 3000; i++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(11, 0) == 0) d0[b] = ~d0[b];
         d1 = 4'($urandom);
`ifdef BITS_DEBOUNCE_STICKY_EN
         for (int b = 0; b < 4; b++) clr0[b] = ($urandom_range(7, 0) == 0);
`endif
         step("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
